// File: rtl/memory_arbiter.sv
`timescale 1ns/1ps
// memory_arbiter: shares one RAM port between an instruction reader and a data reader/writer.
// Build option ARB_FAIR_EN: alternate grants under contention instead of always favouring data.
module memory_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    // instruction requester
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    // data requester
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    // shared RAM port
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ram_ready,
    // status
    output logic        timeout,
    output logic [1:0]  state_dbg
);

    // Handshake: a requester holds its REN/WEN (and address/data) high while its wait
    // output is 1; the access is done in the one cycle where wait drops to 0 with the
    // request still high. ram_ready=1 means the RAM finishes the presented access now.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] cnt;
    logic        ren_q;
    logic        wen_q;
    logic [31:0] addr_q;
    logic [31:0] store_q;
    logic        timeout_q;

    logic        i_pend;
    logic        d_pend;
    logic        grant_d;
    logic        grant_i;
    logic        busy;
    logic        done;
    logic        expire;
    logic        i_cmpl;
    logic        d_cmpl;

    assign i_pend = iREN;
    assign d_pend = dREN | dWEN;

`ifdef ARB_FAIR_EN
    // last_d = 1 when the most recent grant went to the data side
    logic last_d;

    assign grant_d = d_pend && (!i_pend || !last_d);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_d <= 1'b0;
        end else if (state == IDLE) begin
            if (grant_d) begin
                last_d <= 1'b1;
            end else if (grant_i) begin
                last_d <= 1'b0;
            end
        end
    end
`else
    assign grant_d = d_pend;
`endif

    assign grant_i = i_pend && !grant_d;
    assign busy    = (state == IBUSY) || (state == DBUSY);
    assign done    = busy && ram_ready;
    assign expire  = busy && !ram_ready && (cnt == CNT_LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            ren_q     <= 1'b0;
            wen_q     <= 1'b0;
            addr_q    <= '0;
            store_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state   <= DBUSY;
                        cnt     <= '0;
                        ren_q   <= !dWEN;
                        wen_q   <= dWEN;
                        addr_q  <= daddr;
                        store_q <= dWEN ? dstore : 32'd0;
                    end else if (grant_i) begin
                        state   <= IBUSY;
                        cnt     <= '0;
                        ren_q   <= 1'b1;
                        wen_q   <= 1'b0;
                        addr_q  <= iaddr;
                        store_q <= '0;
                    end
                end
                IBUSY, DBUSY: begin
                    // RAM port registers are cleared on exit so IDLE drives all zeros
                    if (done || expire) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        ren_q   <= 1'b0;
                        wen_q   <= 1'b0;
                        addr_q  <= '0;
                        store_q <= '0;
                        if (expire) begin
                            timeout_q <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    ren_q   <= 1'b0;
                    wen_q   <= 1'b0;
                    addr_q  <= '0;
                    store_q <= '0;
                end
            endcase
        end
    end

    // a requester that dropped its request mid-grant gets no data and no wait pulse
    assign i_cmpl = (state == IBUSY) && ram_ready && iREN;
    assign d_cmpl = (state == DBUSY) && ram_ready && d_pend;

    assign iwait = iREN && !i_cmpl;
    assign iload = i_cmpl ? ramload : 32'd0;
    assign dwait = d_pend && !d_cmpl;
    assign dload = d_cmpl ? ramload : 32'd0;

    assign ramREN    = ren_q;
    assign ramWEN    = wen_q;
    assign ramaddr   = addr_q;
    assign ramstore  = store_q;
    assign timeout   = timeout_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_memory_arbiter.sv
`timescale 1ns/1ps
// tb_memory_arbiter: directed scenarios plus random traffic against a grant-level reference model.
module tb_memory_arbiter;

  localparam int TMO = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN, ram_ready;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        iwait, dwait, ramREN, ramWEN, timeout;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic [1:0]  state_dbg;

  memory_arbiter #(.TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready),
    .timeout(timeout), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end within time limit");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // reference model: who holds the RAM, what was latched, how long it has waited
  logic [7:0]  m_owner;   // "N" none, "I" instruction, "D" data
  logic [31:0] m_addr, m_data;
  bit          m_wr, m_tmo, m_lastd;
  int          m_age;
  bit          i_done, d_done;

  task automatic model_reset();
    m_owner = "N";
    m_addr  = 0;
    m_data  = 0;
    m_wr    = 0;
    m_tmo   = 0;
    m_lastd = 0;
    m_age   = 0;
  endtask

  // compare current outputs to the model, then advance the model across the next edge
  task automatic model_eval();
    bit ip, dp, busy, ci, cd, dfirst;
    ip   = iREN;
    dp   = dREN | dWEN;
    busy = (m_owner != "N");
    ci   = (m_owner == "I") && ram_ready;
    cd   = (m_owner == "D") && ram_ready;
    check_eq("iwait",    {31'd0, iwait},  {31'd0, ip && !ci});
    check_eq("iload",    iload,           (ci && ip) ? ramload : 32'd0);
    check_eq("dwait",    {31'd0, dwait},  {31'd0, dp && !cd});
    check_eq("dload",    dload,           (cd && dp) ? ramload : 32'd0);
    check_eq("ramREN",   {31'd0, ramREN}, {31'd0, busy && !m_wr});
    check_eq("ramWEN",   {31'd0, ramWEN}, {31'd0, busy && m_wr});
    check_eq("ramaddr",  ramaddr,         busy ? m_addr : 32'd0);
    check_eq("ramstore", ramstore,        busy ? m_data : 32'd0);
    check_eq("timeout",  {31'd0, timeout}, {31'd0, m_tmo});
    i_done = ci && ip;
    d_done = cd && dp;
`ifdef ARB_FAIR_EN
    dfirst = !m_lastd;
`else
    dfirst = 1'b1;
`endif
    if (RST) begin
      model_reset();
    end else if (!busy) begin
      if (dp && (!ip || dfirst)) begin
        m_owner = "D"; m_addr = daddr; m_wr = dWEN; m_data = dWEN ? dstore : 32'd0;
        m_age = 0; m_lastd = 1;
      end else if (ip) begin
        m_owner = "I"; m_addr = iaddr; m_wr = 0; m_data = 0;
        m_age = 0; m_lastd = 0;
      end
    end else if (ram_ready) begin
      m_owner = "N";
    end else begin
      m_age++;
      if (m_age == TMO) begin
        m_owner = "N";
        m_tmo   = 1;
      end
    end
  endtask

  // driver: apply inputs just after the rising edge, check on the falling edge
  task automatic drive(input bit ir, input bit dr, input bit dw,
                       input logic [31:0] ia, input logic [31:0] da, input logic [31:0] ds,
                       input bit rdy, input logic [31:0] rl, input bit rst);
    @(posedge CLK);
    #1;
    iREN = ir; dREN = dr; dWEN = dw;
    iaddr = ia; daddr = da; dstore = ds;
    ram_ready = rdy; ramload = rl; RST = rst;
    @(negedge CLK);
    model_eval();
  endtask

  task automatic do_reset();
    RST = 1; iREN = 1; dREN = 0; dWEN = 1;
    iaddr = 32'h10; daddr = 32'h20; dstore = 32'h30; ram_ready = 1; ramload = 0;
    repeat (2) @(posedge CLK);
    #1;
    check_eq("rst_state",    {30'd0, state_dbg}, 32'd0);
    check_eq("rst_ramREN",   {31'd0, ramREN},    32'd0);
    check_eq("rst_ramWEN",   {31'd0, ramWEN},    32'd0);
    check_eq("rst_ramaddr",  ramaddr,            32'd0);
    check_eq("rst_timeout",  {31'd0, timeout},   32'd0);
    check_eq("rst_iwait",    {31'd0, iwait},     32'd1);
    check_eq("rst_dwait",    {31'd0, dwait},     32'd1);
    check_eq("rst_dload",    dload,              32'd0);
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  logic [31:0] busy_addr[$];
  logic [31:0] exp_q[$];

  initial begin
    bit          ir, dr, dw, rdy;
    logic [31:0] ia, da, ds;
    model_reset();
    i_done = 0; d_done = 0;
    do_reset();

    // single instruction read, RAM ready on second busy cycle
    drive(1, 0, 0, 32'h40, 0, 0, 0, 32'h0, 0);
    drive(1, 0, 0, 32'h40, 0, 0, 0, 32'h0, 0);
    check_eq("i_rd_ren1",  {31'd0, ramREN}, 32'd1);
    check_eq("i_rd_addr1", ramaddr, 32'h40);
    drive(1, 0, 0, 32'h40, 0, 0, 1, 32'hDEADBEEF, 0);
    check_eq("i_rd_ren2",  {31'd0, ramREN}, 32'd1);
    check_eq("i_rd_iwait", {31'd0, iwait}, 32'd0);
    check_eq("i_rd_iload", iload, 32'hDEADBEEF);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("i_rd_idle", {31'd0, ramREN}, 32'd0);

    // simultaneous instruction read and data write: data goes first
    drive(1, 0, 1, 32'h44, 32'h80, 32'h1234, 0, 0, 0);
    drive(1, 0, 1, 32'h44, 32'h80, 32'h1234, 1, 0, 0);
    check_eq("wr_first_wen",   {31'd0, ramWEN}, 32'd1);
    check_eq("wr_first_store", ramstore, 32'h1234);
    check_eq("wr_first_addr",  ramaddr, 32'h80);
    check_eq("wr_first_iwait", {31'd0, iwait}, 32'd1);
    drive(1, 0, 0, 32'h44, 0, 0, 0, 0, 0);
    check_eq("gap_idle", {31'd0, ramREN | ramWEN}, 32'd0);
    drive(1, 0, 0, 32'h44, 0, 0, 1, 32'h5A5A, 0);
    check_eq("i_after_addr", ramaddr, 32'h44);
    check_eq("i_after_ren",  {31'd0, ramREN}, 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // both requesters held continuously, RAM always ready
    busy_addr.delete();
    for (int k = 0; k < 8; k++) begin
      drive(1, 1, 0, 32'h100, 32'h200, 0, 1, k, 0);
      if (ramREN | ramWEN) busy_addr.push_back(ramaddr);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef ARB_FAIR_EN
    exp_q = '{32'h200, 32'h100, 32'h200, 32'h100};
`else
    exp_q = '{32'h200, 32'h200, 32'h200, 32'h200};
`endif
    check_eq("contend_grants", busy_addr.size(), 4);
    for (int k = 0; k < 4 && k < busy_addr.size(); k++)
      check_eq($sformatf("contend_grant%0d", k), busy_addr[k], exp_q[k]);

    // asynchronous reset in the middle of a data write
    drive(0, 0, 1, 0, 32'h300, 32'h55, 0, 0, 0);
    drive(0, 0, 1, 0, 32'h300, 32'h55, 0, 0, 0);
    check_eq("mid_wr_wen", {31'd0, ramWEN}, 32'd1);
    #2 RST = 1;
    #1;
    check_eq("arst_wen",     {31'd0, ramWEN},    32'd0);
    check_eq("arst_addr",    ramaddr,            32'd0);
    check_eq("arst_timeout", {31'd0, timeout},   32'd0);
    check_eq("arst_dwait",   {31'd0, dwait},     32'd1);
    check_eq("arst_state",   {30'd0, state_dbg}, 32'd0);
    model_reset();
    drive(0, 0, 1, 0, 32'h300, 32'h55, 0, 0, 1);
    check_eq("rst_nogrant", {31'd0, ramWEN}, 32'd0);
    drive(0, 0, 1, 0, 32'h300, 32'h55, 0, 0, 0);
    drive(0, 0, 1, 0, 32'h300, 32'h55, 1, 0, 0);
    check_eq("regrant_wen", {31'd0, ramWEN}, 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // RAM never ready: abort after TMO busy cycles and re-grant
    drive(0, 1, 0, 0, 32'h400, 0, 0, 0, 0);
    for (int k = 0; k < TMO; k++) drive(0, 1, 0, 0, 32'h400, 0, 0, 0, 0);
    check_eq("tmo_last_busy", {31'd0, ramREN}, 32'd1);
    drive(0, 1, 0, 0, 32'h400, 0, 0, 0, 0);
    check_eq("tmo_idle",  {31'd0, ramREN},  32'd0);
    check_eq("tmo_flag",  {31'd0, timeout}, 32'd1);
    check_eq("tmo_dwait", {31'd0, dwait},   32'd1);
    drive(0, 1, 0, 0, 32'h400, 0, 1, 32'h77, 0);
    check_eq("tmo_regrant", {31'd0, ramREN}, 32'd1);
    check_eq("tmo_dload",   dload, 32'h77);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("tmo_sticky", {31'd0, timeout}, 32'd1);

    // random traffic; requests held until served or occasionally dropped
    do_reset();
    ir = 0; dr = 0; dw = 0; ia = 0; da = 0; ds = 0;
    for (int c = 0; c < 800; c++) begin
      if (ir && (i_done || $urandom_range(0, 11) == 0)) ir = 0;
      else if (!ir && $urandom_range(0, 2) == 0) begin ir = 1; ia = $urandom; end
      if ((dr | dw) && (d_done || $urandom_range(0, 11) == 0)) begin dr = 0; dw = 0; end
      else if (!(dr | dw) && $urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 3))
          0, 1:    begin dr = 1; dw = 0; end
          2:       begin dr = 0; dw = 1; end
          default: begin dr = 1; dw = 1; end
        endcase
        da = $urandom; ds = $urandom;
      end
      rdy = ($urandom_range(0, 3) == 0);
      drive(ir, dr, dw, ia, da, ds, rdy, $urandom, 0);
    end

    do_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
